fifo_wr_ctrl: RTL
=================

# fifo_wr_ctrl

Write-domain pointer and flag controller for the asynchronous FIFO. It consumes the gray-coded read pointer after the read-to-write double-flop synchronizer, and produces the following:
- the binary write address and write strobe for the dual-port memory;
- the gray write pointer that the write-to-read synchronizer carries across;
- registered full, almost-full, fill-level and sticky overflow status.

## Interface
Parameters:
- ADDR, 4, address width; FIFO depth = 2^ADDR; ADDR >= 2
- AF_LEVEL, 12, almost-full threshold in entries; 1 <= AF_LEVEL <= 2^ADDR

Ports:
- i_clk  input  1  write-domain clock; all state updates on its rising edge
- i_rst  input  1  synchronous, active-high reset
- i_wr_en  input  1  write request from the producer
- i_ovf_clr  input  1  clears o_overflow
- i_rd_ptr_sync  input  ADDR+1  gray read pointer, already synchronized into i_clk
- o_wr_fire  output  1  memory write strobe, combinational: i_wr_en & ~o_full & ~i_rst
- o_wr_addr  output  ADDR  binary write address, equal to wbin[ADDR-1:0]
- o_wr_ptr  output  ADDR+1  registered gray write pointer, sent to the synchronizer
- o_full  output  1  registered full flag
- o_almost_full  output  1  registered; set when level >= AF_LEVEL
- o_wr_level  output  ADDR+1  registered fill level, 0 to 2^ADDR
- o_overflow  output  1  sticky flag; a write was attempted while full

## Operation
- Internal binary pointer wbin, ADDR+1 bits. Next-state values:
  - wbin_n = wbin + o_wr_fire, wrapping modulo 2^(ADDR+1)
  - wgray_n = wbin_n ^ (wbin_n >> 1)
- Full:
  - full_n = (wgray_n == {~i_rd_ptr_sync[ADDR:ADDR-1], i_rd_ptr_sync[ADDR-2:0]})
  - o_full <= full_n
- Level:
  - rbin = gray2bin(i_rd_ptr_sync)
  - level_n = wbin_n - rbin, modulo 2^(ADDR+1)
  - o_wr_level <= level_n
  - o_almost_full <= (level_n >= AF_LEVEL)
- Conservatism: the read pointer is at least 2 cycles stale, so level, full and almost-full are pessimistic. They may over-report but never under-report. This behaviour is required.
- Overflow:
  - o_overflow <= (i_wr_en & o_full) | (o_overflow & ~i_ovf_clr)
  - Set wins over a simultaneous clear.
- A write while full is dropped: o_wr_fire stays 0 and the pointer is unchanged.
- Reset: wbin, o_wr_ptr, o_full, o_almost_full, o_wr_level and o_overflow all go to 0. o_wr_fire is 0 while i_rst is high. Reset overrides any write in the same cycle.

## Timing
- o_wr_fire is valid in the same cycle as i_wr_en. Memory captures data and o_wr_addr on that edge.
- o_wr_addr, o_wr_ptr, o_full, o_wr_level and o_almost_full reflect a write on the edge that consumes it, so latency is 1 cycle.
- o_full asserts on the edge of the write that fills the FIFO. A back-to-back write in the following cycle is therefore blocked.
- o_full deasserts on the first edge after i_rd_ptr_sync advances, i.e. 1 cycle after the synchronizer output changes.
- A write and a read-pointer advance in the same cycle are both reflected: level is unchanged and full is re-evaluated.
- Wrap-around: wbin goes from 2^(ADDR+1)-1 to 0, the gray pointer changes by exactly 1 bit, and the address goes from 2^ADDR-1 to 0.
- A reset in mid-stream takes effect on the next edge. The read-side reset is handled elsewhere and must be co-asserted.

## Structure
- Shared package fifo_pkg holds:
  - the default ADDR and AF_LEVEL
  - the function bin2gray
- One sub-module, gray2bin: parameter W, combinational prefix-XOR. It is reused by the read-side controller.
- No other hierarchy.

## Test plan
All scenarios use ADDR=4 (depth 16) and AF_LEVEL=12.
1. Reset: i_rst=1 for 2 cycles with i_wr_en=1 -> o_wr_fire=0, all outputs 0; after release, the first write uses o_wr_addr=0.
2. i_rd_ptr_sync=0, 16 consecutive writes -> o_wr_addr steps 0..15; o_almost_full rises on the 12th edge; o_full rises on the 16th edge; o_wr_ptr=5'b11000; o_wr_level=16.
3. Full, i_wr_en held for 3 cycles -> o_wr_fire=0, o_wr_ptr stays 5'b11000, o_overflow=1 and stays set; i_ovf_clr pulse clears it on the next edge.
4. Full, drive i_rd_ptr_sync=5'b00001 -> o_full=0 and o_wr_level=15 on the next edge; the next write sets o_full again.
5. 40 writes with i_rd_ptr_sync tracking gray(wbin-4) -> o_wr_addr wraps 15->0, o_wr_ptr goes 5'b10000->5'b00000 after 32 writes, o_full never asserts, o_wr_level holds at 4.
6. Full, i_wr_en=1 and i_ovf_clr=1 in the same cycle -> o_overflow remains 1.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared defaults and pointer-encoding helpers for the
//               asynchronous FIFO write/read controllers.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Default pointer address width (depth = 2**ADDR)
    localparam int unsigned C_ADDR_DEFAULT     = 4;
    // Default almost-full threshold in entries
    localparam int unsigned C_AF_LEVEL_DEFAULT = 12;
    // Widest pointer the encoding helper handles
    localparam int unsigned C_CODE_MAX_W       = 32;

    // Binary to reflected-gray conversion. Callers zero-extend into the wide
    // argument and cast the result back down to their pointer width.
    function automatic logic [C_CODE_MAX_W-1:0] bin2gray(
        input logic [C_CODE_MAX_W-1:0] bin
    );
        return bin ^ (bin >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray2bin.sv
`default_nettype none
// ============================================================================
// Module      : gray2bin
// Description : Combinational gray-to-binary converter (prefix XOR from the
//               MSB down). Shared by the write- and read-side controllers.
// Revision    : 1.0 - initial release
// ============================================================================
module gray2bin #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    // Each binary bit is the XOR of all gray bits at or above its position
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        assign o_bin[gi] = ^i_gray[W-1:gi];
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_ctrl
// Description : Write-domain pointer and flag controller for the async FIFO.
//               Generates the memory write strobe/address, the gray write
//               pointer for the write-to-read synchronizer and registered
//               full / almost-full / level / sticky-overflow status computed
//               against the synchronized (stale) read pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR     = C_ADDR_DEFAULT,
    parameter int unsigned AF_LEVEL = C_AF_LEVEL_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_wr_en,
    input  logic            i_ovf_clr,
    input  logic [ADDR:0]   i_rd_ptr_sync,
    output logic            o_wr_fire,
    output logic [ADDR-1:0] o_wr_addr,
    output logic [ADDR:0]   o_wr_ptr,
    output logic            o_full,
    output logic            o_almost_full,
    output logic [ADDR:0]   o_wr_level,
    output logic            o_overflow
);

    // Threshold held at pointer width so the compare is width-matched
    localparam logic [ADDR:0] C_AF_LEVEL = (ADDR+1)'(AF_LEVEL);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR:0] r_wbin_q,  w_wbin_d;
    logic [ADDR:0] r_wgray_q, w_wgray_d;
    logic          r_full_q,  w_full_d;
    logic          r_af_q,    w_af_d;
    logic [ADDR:0] r_level_q, w_level_d;
    logic          r_ovf_q,   w_ovf_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic          w_wr_fire;
    logic [ADDR:0] w_rbin;
    logic [ADDR:0] w_rd_full_cmp;

    // Read pointer arrives gray-coded; level arithmetic needs binary
    gray2bin #(
        .W (ADDR + 1)
    ) u_rd_g2b (
        .i_gray (i_rd_ptr_sync),
        .o_bin  (w_rbin)
    );

    // Write is accepted only when not full and not in reset; a write while
    // full is dropped so the pointer never laps the reader.
    assign w_wr_fire = i_wr_en & ~r_full_q & ~i_rst;

    // Full when the write pointer is exactly one lap ahead: in gray code
    // that is the read pointer with its two MSBs inverted.
    assign w_rd_full_cmp = {~i_rd_ptr_sync[ADDR:ADDR-1], i_rd_ptr_sync[ADDR-2:0]};

    // Next-state for pointers and status, all evaluated on the post-write pointer
    always_comb begin
        w_wbin_d  = r_wbin_q + {{ADDR{1'b0}}, w_wr_fire};
        w_wgray_d = (ADDR+1)'(bin2gray(C_CODE_MAX_W'(w_wbin_d)));
        w_full_d  = (w_wgray_d == w_rd_full_cmp);
        // Stale read pointer makes this level an over-estimate, never under
        w_level_d = w_wbin_d - w_rbin;
        w_af_d    = (w_level_d >= C_AF_LEVEL);
        // Sticky overflow; a new attempted write wins over a clear
        w_ovf_d   = (i_wr_en & r_full_q) | (r_ovf_q & ~i_ovf_clr);
    end

    // State register with synchronous reset overriding any same-cycle write
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wbin_q  <= '0;
            r_wgray_q <= '0;
            r_full_q  <= 1'b0;
            r_af_q    <= 1'b0;
            r_level_q <= '0;
            r_ovf_q   <= 1'b0;
        end else begin
            r_wbin_q  <= w_wbin_d;
            r_wgray_q <= w_wgray_d;
            r_full_q  <= w_full_d;
            r_af_q    <= w_af_d;
            r_level_q <= w_level_d;
            r_ovf_q   <= w_ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_wr_fire     = w_wr_fire;
    assign o_wr_addr     = r_wbin_q[ADDR-1:0];
    assign o_wr_ptr      = r_wgray_q;
    assign o_full        = r_full_q;
    assign o_almost_full = r_af_q;
    assign o_wr_level    = r_level_q;
    assign o_overflow    = r_ovf_q;

endmodule
`default_nettype wire
